// File: rtl/i2c_reg_target.sv
// I2C target with an 8-bit auto-incrementing register pointer and a fabric-side register port.
// SCL/SDA are oversampled in the clk domain; the target only ever pulls SDA low.
`timescale 1ns/1ps
module i2c_reg_target #(
  parameter logic [6:0]  CHIP_ADDR   = 7'h39,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       txn_done
);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       drive_low_q, drive_low_d;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       wr_en_q, wr_en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Synchronizers idle high so reset never looks like a bus edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      drive_low_q <= 1'b0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b0;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 8'd0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      drive_low_q <= drive_low_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    drive_low_d = drive_low_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    wr_en_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (stop_det) begin
      state_d     = StIdle;
      drive_low_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = busy_q;
    end else if (start_det) begin
      state_d     = StAddr;
      bit_cnt_d   = 3'd0;
      drive_low_d = 1'b0;
      mack_d      = 1'b0;
    end else begin
      case (state_q)
        StIdle: ;

        StAddr: begin
          if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d = sda_s;
              if (shift_q == CHIP_ADDR) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
              end else begin
                state_d = StIgnore;
                busy_d  = 1'b0;
              end
            end
          end
        end

        // drive_low_q doubles as the ACK phase: first fall asserts, second fall ends the slot.
        StAddrAck: begin
          if (scl_fall) begin
            if (!drive_low_q) begin
              drive_low_d = 1'b1;
            end else if (rw_q) begin
              shift_d     = reg_rdata[6:0];
              drive_low_d = ~reg_rdata[7];
              bit_cnt_d   = 3'd1;
              state_d     = StRdata;
            end else begin
              drive_low_d = 1'b0;
              bit_cnt_d   = 3'd0;
              state_d     = StPtr;
            end
          end
        end

        StPtr: begin
          if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              reg_addr_d = {shift_q, sda_s};
              state_d    = StPtrAck;
            end
          end
        end

        StPtrAck: begin
          if (scl_fall) begin
            if (!drive_low_q) begin
              drive_low_d = 1'b1;
            end else begin
              drive_low_d = 1'b0;
              bit_cnt_d   = 3'd0;
              state_d     = StWdata;
            end
          end
        end

        StWdata: begin
          if (scl_rise) begin
            shift_d   = {shift_q[5:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              reg_wdata_d = {shift_q, sda_s};
              wr_en_d     = 1'b1;
              state_d     = StWdataAck;
            end
          end
        end

        StWdataAck: begin
          if (scl_fall) begin
            if (!drive_low_q) begin
              drive_low_d = 1'b1;
            end else begin
              drive_low_d = 1'b0;
              reg_addr_d  = reg_addr_q + 8'd1;
              bit_cnt_d   = 3'd0;
              state_d     = StWdata;
            end
          end
        end

        // bit_cnt counts bits already driven; wrap to 0 means bit 0 is on the bus.
        StRdata: begin
          if (scl_fall) begin
            if (bit_cnt_q != 3'd0) begin
              drive_low_d = ~shift_q[6];
              shift_d     = {shift_q[5:0], 1'b0};
              bit_cnt_d   = bit_cnt_q + 3'd1;
            end else begin
              drive_low_d = 1'b0;
              reg_addr_d  = reg_addr_q + 8'd1;
              mack_d      = 1'b0;
              state_d     = StRdataAck;
            end
          end
        end

        StRdataAck: begin
          if (scl_rise) begin
            if (!sda_s) begin
              mack_d = 1'b1;
            end else begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && mack_q) begin
            mack_d      = 1'b0;
            shift_d     = reg_rdata[6:0];
            drive_low_d = ~reg_rdata[7];
            bit_cnt_d   = 3'd1;
            state_d     = StRdata;
          end
        end

        StIgnore: begin
          drive_low_d = 1'b0;
          busy_d      = 1'b0;
        end

        default: begin
          state_d     = StIdle;
          drive_low_d = 1'b0;
        end
      endcase
    end
  end

  assign sda       = drive_low_q ? 1'b0 : 1'bz;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr_en = wr_en_q;
  assign busy      = busy_q;
  assign txn_done  = done_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: bit-banged I2C master, register model, write/done monitor.
`timescale 1ns/1ps
module tb_i2c_reg_target;

  localparam int Q = 100;  // quarter SCL period; clk period is 10

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr_en, busy, txn_done;
  logic [7:0] mem [256];

  int         n_checks = 0;
  int         n_pass = 0;
  int         n_wr, n_done;
  logic [7:0] wr_addr[$];
  logic [7:0] wr_data[$];
  bit         busy_seen;

  pullup (sda);
  assign sda       = m_low ? 1'b0 : 1'bz;
  assign reg_rdata = mem[reg_addr];

  always #5 clk = ~clk;

  i2c_reg_target #(
    .CHIP_ADDR   (7'h39),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .txn_done  (txn_done)
  );

  always @(negedge clk) begin
    if (reg_wr_en === 1'b1) begin
      n_wr++;
      wr_addr.push_back(reg_addr);
      wr_data.push_back(reg_wdata);
    end
    if (txn_done === 1'b1) n_done++;
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_mon();
    n_wr = 0;
    n_done = 0;
    busy_seen = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic bus_start();
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    ack = (sda === 1'b0);
    #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      m_low = 1'b0; #Q;
      scl = 1'b1;   #Q;
      v[i] = sda;
      #Q;
      scl = 1'b0;   #Q;
    end
    m_low = mack; #Q;
    scl = 1'b1;   #(2*Q);
    scl = 1'b0;   #Q;
    b = v;
  endtask

  initial begin
    logic       a0, a1, a2, a3;
    logic [7:0] d0, d1;
    logic [2:0] bits;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h96] = 8'hC3;
    mem[8'h97] = 8'h5A;
    clear_mon();
    reset = 1'b0;
    scl   = 1'b1;
    m_low = 1'b0;
    #23;
    check_eq("rst_reg_addr", reg_addr, 8'h00);
    check_eq("rst_reg_wdata", reg_wdata, 8'h00);
    check_eq("rst_wr_en", reg_wr_en, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_txn_done", txn_done, 1'b0);
    check_eq("rst_sda", sda, 1'b1);
    reset = 1'b1;
    #Q;

    // Single write 0x10 to 0x41
    clear_mon();
    bus_start();
    send_byte(8'h72, a0);
    check_eq("w1_busy_after_addr", busy, 1'b1);
    send_byte(8'h41, a1);
    send_byte(8'h10, a2);
    bus_stop();
    #Q;
    check_eq("w1_acks", {a0, a1, a2}, 3'b111);
    check_eq("w1_n_wr", n_wr, 1);
    check_eq("w1_wr_addr", wr_addr[0], 8'h41);
    check_eq("w1_wr_data", wr_data[0], 8'h10);
    check_eq("w1_txn_done", n_done, 1);
    check_eq("w1_busy_end", busy, 1'b0);
    check_eq("w1_reg_addr", reg_addr, 8'h42);

    // Burst write across pointer wrap
    clear_mon();
    bus_start();
    send_byte(8'h72, a0);
    send_byte(8'hFF, a1);
    send_byte(8'hAA, a2);
    send_byte(8'h55, a3);
    bus_stop();
    #Q;
    check_eq("w2_acks", {a0, a1, a2, a3}, 4'b1111);
    check_eq("w2_n_wr", n_wr, 2);
    check_eq("w2_wr0", {wr_addr[0], wr_data[0]}, 16'hFFAA);
    check_eq("w2_wr1", {wr_addr[1], wr_data[1]}, 16'h0055);
    check_eq("w2_reg_addr", reg_addr, 8'h01);
    check_eq("w2_txn_done", n_done, 1);

    // Wrong address 0x3A: silent
    clear_mon();
    bus_start();
    send_byte(8'h74, a0);
    send_byte(8'h11, a1);
    send_byte(8'h22, a2);
    bus_stop();
    #Q;
    check_eq("na_acks", {a0, a1, a2}, 3'b000);
    check_eq("na_n_wr", n_wr, 0);
    check_eq("na_busy_seen", busy_seen, 1'b0);
    check_eq("na_txn_done", n_done, 0);
    check_eq("na_reg_addr", reg_addr, 8'h01);

    // Pointer write, repeated START, two-byte read ending in NACK
    clear_mon();
    bus_start();
    send_byte(8'h72, a0);
    send_byte(8'h96, a1);
    bus_start();
    send_byte(8'h73, a2);
    recv_byte(1'b1, d0);
    recv_byte(1'b0, d1);
    check_eq("rd_busy_after_nack", busy, 1'b0);
    bus_stop();
    #Q;
    check_eq("rd_acks", {a0, a1, a2}, 3'b111);
    check_eq("rd_byte0", d0, 8'hC3);
    check_eq("rd_byte1", d1, 8'h5A);
    check_eq("rd_reg_addr", reg_addr, 8'h98);
    check_eq("rd_n_wr", n_wr, 0);
    check_eq("rd_txn_done", n_done, 0);

    // Reset while the target drives bit 4 (a 0) of a read byte
    bus_start();
    send_byte(8'h72, a0);
    send_byte(8'h96, a1);
    bus_start();
    send_byte(8'h73, a2);
    bits = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      m_low = 1'b0; #Q;
      scl = 1'b1;   #Q;
      bits[i] = sda;
      #Q;
      scl = 1'b0;   #Q;
    end
    check_eq("mr_first_bits", bits, 3'b110);
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    check_eq("mr_sda_driven", sda, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("mr_sda_released", sda, 1'b1);
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_reg_addr", reg_addr, 8'h00);
    #(Q-1);
    scl = 1'b0; #Q;
    reset = 1'b1; #Q;
    clear_mon();
    bus_start();
    send_byte(8'h72, a0);
    send_byte(8'h20, a1);
    send_byte(8'h77, a2);
    bus_stop();
    #Q;
    check_eq("mr_acks", {a0, a1, a2}, 3'b111);
    check_eq("mr_n_wr", n_wr, 1);
    check_eq("mr_wr", {wr_addr[0], wr_data[0]}, 16'h2077);
    check_eq("mr_txn_done", n_done, 1);

    // STOP after 5 bits of a data byte
    clear_mon();
    bus_start();
    send_byte(8'h72, a0);
    send_byte(8'h50, a1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    bus_stop();
    #Q;
    check_eq("ps_acks", {a0, a1}, 2'b11);
    check_eq("ps_n_wr", n_wr, 0);
    check_eq("ps_txn_done", n_done, 1);
    check_eq("ps_reg_addr", reg_addr, 8'h50);
    check_eq("ps_busy", busy, 1'b0);
    check_eq("ps_sda", sda, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
